inst_fetch: RTL and testbench

Instruction fetch unit. It consumes the fetch address issued by the PC register and assembles one 32-bit instruction from four little-endian byte reads over the byte-wide memory port. It then presents the instruction to decode with a valid/ready handshake. It raises stall_req back to the PC register while busy and discards work in flight on a taken jump.

---
 rtl/inst_fetch.sv | 153 +++++++++++++++
 tb/tb_inst_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit.
// It takes a fetch address from the PC register and reads the instruction as
// INST_W/8 little-endian bytes over a byte-wide memory port. The assembled
// instruction is then offered to decode with a valid/ready handshake.
//
// Ports:
//   clk_in, rst_in     clock (rising edge) and async active-high reset
//   rdy_in             global ready; low freezes every register
//   fetch_pc           next fetch address, accepted when idle
//   jmp_tak            taken jump: flush the fetch in progress
//   stall_req          asserted when fetch_pc cannot be accepted this cycle
//   mem_req/mem_addr   byte read request and address
//   mem_gnt            arbiter accepted the request this cycle
//   mem_rvalid/rdata   read byte, valid one cycle after its grant
//   id_ready           decode accepts the held instruction
//   inst_valid/inst/inst_pc  assembled instruction and its address
module inst_fetch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              jmp_tak,
  output logic              stall_req,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  input  logic              id_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int unsigned NBYTES = INST_W / 8;
  localparam int unsigned CW     = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] C_NBYTES = CW'(NBYTES);
  localparam logic [CW-1:0] C_LAST   = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_base;
  logic [CW-1:0]       r_issue_cnt;
  logic [CW-1:0]       r_recv_cnt;
  logic                r_drop;
  logic [INST_W-1:0]   r_inst;
  logic [ADDR_W-1:0]   r_inst_pc;
  logic                r_inst_valid;

  logic                w_grant;
  logic                w_take_byte;
  logic                w_last_byte;
  logic [CW+2:0]       w_shamt;
  logic [INST_W-1:0]   w_byte_mask;
  logic [INST_W-1:0]   w_byte_data;

  // Combinational outputs and byte-lane steering
  always_comb begin
    stall_req   = (r_state != IDLE) | ~rdy_in;
    mem_req     = rdy_in & (r_state == FETCH) & (r_issue_cnt < C_NBYTES);
    mem_addr    = r_base + {{(ADDR_W-CW){1'b0}}, r_issue_cnt};
    w_grant     = mem_req & mem_gnt;
    // A byte is only accepted if one is actually outstanding and it is not
    // the stale byte left over from a flush.
    w_take_byte = (r_state == FETCH) & mem_rvalid & ~r_drop &
                  (r_recv_cnt < r_issue_cnt);
    w_last_byte = (r_recv_cnt == C_LAST);
    w_shamt     = {r_recv_cnt, 3'b000};
    w_byte_mask = {{(INST_W-8){1'b0}}, 8'hFF} << w_shamt;
    w_byte_data = {{(INST_W-8){1'b0}}, mem_rdata} << w_shamt;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (rdy_in) begin
      if (jmp_tak) begin
        w_state_next = IDLE;
      end else begin
        case (r_state)
          IDLE:    w_state_next = FETCH;
          FETCH:   if (w_take_byte && w_last_byte) w_state_next = HOLD;
          HOLD:    if (id_ready) w_state_next = IDLE;
          default: w_state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Datapath registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_base       <= '0;
      r_issue_cnt  <= '0;
      r_recv_cnt   <= '0;
      r_drop       <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
    end else if (rdy_in) begin
      if (jmp_tak) begin
        r_issue_cnt  <= '0;
        r_recv_cnt   <= '0;
        r_inst_valid <= 1'b0;
        // Remember that a byte granted on the flush edge will still return.
        r_drop       <= w_grant;
      end else begin
        r_drop <= 1'b0;
        case (r_state)
          IDLE: begin
            r_base      <= fetch_pc;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
          end
          FETCH: begin
            if (w_grant) r_issue_cnt <= r_issue_cnt + 1'b1;
            if (w_take_byte) begin
              r_inst     <= (r_inst & ~w_byte_mask) | w_byte_data;
              r_recv_cnt <= r_recv_cnt + 1'b1;
              if (w_last_byte) begin
                r_inst_pc    <= r_base;
                r_inst_valid <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (id_ready) r_inst_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_inst_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: table of fetch scenarios plus hand-written flush
// and reset sequences; completed instructions are checked through a queue.
module tb_inst_fetch;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] fetch_pc;
  logic        jmp_tak;
  logic        stall_req;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  inst_fetch #(.ADDR_W(32), .INST_W(32)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .fetch_pc  (fetch_pc),
    .jmp_tak   (jmp_tak),
    .stall_req (stall_req),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .id_ready  (id_ready),
    .inst_valid(inst_valid),
    .inst      (inst),
    .inst_pc   (inst_pc)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_inst;
    int          gap_idx;
    int          gap_len;
    int          frz_idx;
    int          frz_len;
    int          rd_wait;
    int          exp_lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  vec_t vflush;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h1000: return 8'h13;
      32'h1001: return 8'h05;
      32'h1002: return 8'h10;
      32'h1003: return 8'h00;
      32'h2000: return 8'h93;
      32'h2001: return 8'h00;
      32'h2002: return 8'h00;
      32'h2003: return 8'h00;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // One clock edge. Called at negedge+1 with inputs settled; models the
  // memory (data one cycle after a grant) and pops the scoreboard on a
  // decode handshake. Returns at the following negedge.
  task automatic step();
    logic        g;
    logic [31:0] a;
    exp_t        e;
    g = mem_req & mem_gnt;
    a = mem_addr;
    if (rdy_in && inst_valid && id_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", 64'(inst_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_inst", 64'(inst), 64'(e.inst));
        chk("sb_pc", 64'(inst_pc), 64'(e.pc));
      end
    end
    @(posedge clk_in);
    #1;
    mem_rvalid = g;
    mem_rdata  = g ? mem_byte(a) : 8'h00;
    @(negedge clk_in);
  endtask

  task automatic run_fetch(input vec_t v, input bit release_it);
    int issued;
    int gap_rem;
    int frz_rem;
    int n;
    rdy_in   = 1'b1;
    jmp_tak  = 1'b0;
    id_ready = 1'b0;
    mem_gnt  = 1'b1;
    fetch_pc = v.pc;
    if (release_it) sb_q.push_back('{inst: v.exp_inst, pc: v.pc});
    #1;
    chk("idle_stall", 64'(stall_req), 64'd0);
    step();
    issued  = 0;
    gap_rem = v.gap_len;
    frz_rem = v.frz_len;
    n       = 0;
    while (!inst_valid && n < 40) begin
      rdy_in  = 1'b1;
      jmp_tak = 1'b0;
      mem_gnt = 1'b1;
      if (issued == v.gap_idx && gap_rem > 0) begin
        mem_gnt = 1'b0;
        gap_rem--;
      end else if (issued == v.frz_idx && frz_rem > 0) begin
        rdy_in  = 1'b0;
        jmp_tak = 1'b1;   // must be ignored while frozen
        frz_rem--;
      end
      #1;
      chk("fetch_stall", 64'(stall_req), 64'd1);
      chk("fetch_req", 64'(mem_req), 64'(rdy_in && issued < 4));
      if (issued < 4) chk("fetch_addr", 64'(mem_addr), 64'(32'(v.pc + 32'(issued))));
      if (rdy_in && mem_gnt && issued < 4) issued++;
      step();
      n++;
    end
    rdy_in  = 1'b1;
    jmp_tak = 1'b0;
    chk("latency", 64'(n), 64'(v.exp_lat));
    for (int r = 0; r < v.rd_wait; r++) begin
      chk("hold_valid", 64'(inst_valid), 64'd1);
      chk("hold_inst", 64'(inst), 64'(v.exp_inst));
      chk("hold_pc", 64'(inst_pc), 64'(v.pc));
      chk("hold_req", 64'(mem_req), 64'd0);
      chk("hold_stall", 64'(stall_req), 64'd1);
      mem_rvalid = 1'b1;  // stray byte in HOLD must not disturb inst
      mem_rdata  = 8'hFF;
      #1;
      step();
    end
    chk("done_valid", 64'(inst_valid), 64'd1);
    chk("done_inst", 64'(inst), 64'(v.exp_inst));
    chk("done_pc", 64'(inst_pc), 64'(v.pc));
    if (release_it) begin
      id_ready = 1'b1;
      #1;
      step();
      id_ready = 1'b0;
      #1;
      chk("rel_valid", 64'(inst_valid), 64'd0);
      chk("rel_stall", 64'(stall_req), 64'd0);
    end
  endtask

  initial begin
    rst_in     = 1'b1;
    rdy_in     = 1'b1;
    fetch_pc   = '0;
    jmp_tak    = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    id_ready   = 1'b0;

    //          pc            inst          gap     freeze  rd lat
    vecs[0] = '{32'h0000_1000, 32'h0010_0513, -1, 0, -1, 0, 0, 5};
    vecs[1] = '{32'h0000_1000, 32'h0010_0513,  2, 2, -1, 0, 1, 7};
    vecs[2] = '{32'h0000_2000, 32'h0000_0093, -1, 0, -1, 0, 3, 5};
    vecs[3] = '{32'hFFFF_FFFE, 32'h5B5A_A5A4, -1, 0, -1, 0, 0, 5};
    vecs[4] = '{32'h0000_3000, 32'h5958_5B5A,  0, 1, -1, 0, 0, 6};
    vecs[5] = '{32'h0000_1000, 32'h0010_0513,  2, 1,  2, 4, 0, 10};
    vflush  = '{32'h0000_2000, 32'h0000_0093, -1, 0, -1, 0, 0, 5};

    repeat (2) @(negedge clk_in);
    #1;
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_pc", 64'(inst_pc), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;

    for (int i = 0; i < 6; i++) run_fetch(vecs[i], 1'b1);

    // Flush on the edge that grants the second byte of a fetch at 0x1000
    rdy_in = 1'b1; jmp_tak = 1'b0; id_ready = 1'b0; mem_gnt = 1'b1;
    fetch_pc = 32'h1000;
    #1;
    step();
    #1;
    chk("fl_addr0", 64'(mem_addr), 64'h1000);
    step();
    jmp_tak = 1'b1;
    #1;
    chk("fl_addr1", 64'(mem_addr), 64'h1001);
    chk("fl_req", 64'(mem_req), 64'd1);
    step();
    jmp_tak = 1'b0;
    #1;
    chk("fl_stall", 64'(stall_req), 64'd0);
    chk("fl_valid", 64'(inst_valid), 64'd0);
    chk("fl_req_off", 64'(mem_req), 64'd0);
    run_fetch(vflush, 1'b1);

    // Flush while idle: fetch_pc is not accepted on that edge
    fetch_pc = 32'h1000;
    jmp_tak  = 1'b1;
    #1;
    step();
    jmp_tak = 1'b0;
    #1;
    chk("jidle_stall", 64'(stall_req), 64'd0);
    chk("jidle_req", 64'(mem_req), 64'd0);

    // Asynchronous reset while holding an instruction
    run_fetch(vecs[4], 1'b0);
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_valid", 64'(inst_valid), 64'd0);
    chk("arst_stall", 64'(stall_req), 64'd0);
    chk("arst_req", 64'(mem_req), 64'd0);
    chk("arst_inst", 64'(inst), 64'd0);
    @(negedge clk_in);
    rst_in     = 1'b0;
    mem_rvalid = 1'b0;
    run_fetch(vecs[0], 1'b1);

    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
